// File: rtl/simple_risc_pkg.sv
// Shared definitions for the simple RISC pipeline: memory-access FSM encoding,
// timeout default, word-alignment mask and the captured-instruction payload.
package simple_risc_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned REG_IDX_W           = 4;
  localparam int unsigned TMO_CNT_W           = 8;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  // Low address bits that must be zero for a word access
  localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    MA_IDLE   = 2'd0,
    MA_ACCESS = 2'd1,
    MA_ERROR  = 2'd2
  } ma_state_e;

  // Instruction fields held by the memory-access stage
  typedef struct packed {
    logic                 is_ld;
    logic                 is_st;
    logic                 is_wb;
    logic                 is_call;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      alu;
    logic [XLEN-1:0]      op2;
    logic [XLEN-1:0]      pc;
  } ma_instr_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr & WORD_ALIGN_MASK) == '0;
  endfunction

endpackage

// File: rtl/ma_timeout_ctr.sv
// Memory-wait timeout counter.
// Ports: Clk, reset_n (async active-low), clear (zero count), enable (count one
// unanswered cycle), limit (timeout in cycles), expired (this enabled cycle
// brings the count to limit).
module ma_timeout_ctr
  import simple_risc_pkg::*;
#(
  parameter int unsigned CNT_W = TMO_CNT_W
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  localparam int unsigned EXT_W = CNT_W + 1;

  logic [CNT_W-1:0] count_q;

  // Wait-cycle count
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Evaluated one bit wider so the increment can never wrap in the compare
  assign expired = enable && ((EXT_W'(count_q) + EXT_W'(1)) >= EXT_W'(limit));

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: passes ALU results through with one cycle of
// latency, runs one load/store at a time against a req/ack memory port, aborts
// on misalignment or timeout into a sticky error state.
// Ports: Clk, reset_n (async assert, synchronised release); upstream
// instruction fields + stall; memory req/we/addr/wdata/rdata/ack; downstream
// registered valid_out/isWb/isCall/isLd/Rd/aluResult/ldResult/pc_current/mem_err.
// mem_* and stall are combinational.
module ma_stage
  import simple_risc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 valid_in,
  input  logic                 isLd_in,
  input  logic                 isSt,
  input  logic                 isWb_in,
  input  logic                 isCall_in,
  input  logic [REG_IDX_W-1:0] Rd_in,
  input  logic [XLEN-1:0]      aluResult_in,
  input  logic [XLEN-1:0]      op2,
  input  logic [XLEN-1:0]      pc_in,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_ack,
  output logic                 valid_out,
  output logic                 isWb,
  output logic                 isCall,
  output logic                 isLd,
  output logic [REG_IDX_W-1:0] Rd,
  output logic [XLEN-1:0]      aluResult,
  output logic [XLEN-1:0]      ldResult,
  output logic [XLEN-1:0]      pc_current,
  output logic                 mem_err
);

  logic [1:0]      rst_sync_q;
  logic            rst_n_sync;
  ma_state_e       state_q, state_d;
  ma_instr_t       instr_q, instr_in;
  logic            mem_op, aligned;
  logic            ctr_clear, ctr_en, tmo_expired;
  logic            valid_q, wb_q, err_q;
  logic [XLEN-1:0] ld_q;

  // Reset asserts immediately, releases two clocks later
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_sync = rst_sync_q[1];

  // Decode; a load with isSt also set stays a load
  assign instr_in = '{is_ld:   isLd_in,
                      is_st:   isSt & ~isLd_in,
                      is_wb:   isWb_in,
                      is_call: isCall_in,
                      rd:      Rd_in,
                      alu:     aluResult_in,
                      op2:     op2,
                      pc:      pc_in};
  assign mem_op  = isLd_in | isSt;
  assign aligned = is_word_aligned(aluResult_in);

  ma_timeout_ctr #(.CNT_W(TMO_CNT_W)) u_tmo (
    .Clk     (Clk),
    .reset_n (rst_n_sync),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .limit   (TMO_CNT_W'(MEM_TIMEOUT)),
    .expired (tmo_expired)
  );

  // State register
  always_ff @(posedge Clk or negedge rst_n_sync) begin
    if (!rst_n_sync) state_q <= MA_IDLE;
    else             state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MA_IDLE: begin
        if (valid_in && mem_op) begin
          if (!aligned)      state_d = MA_ERROR;
          else if (!mem_ack) state_d = MA_ACCESS;
        end
      end
      MA_ACCESS: begin
        if (mem_ack)          state_d = MA_IDLE;
        else if (tmo_expired) state_d = MA_ERROR;
      end
      MA_ERROR: state_d = MA_ERROR;
      default:  state_d = MA_IDLE;
    endcase
  end

  // Memory port, stall and counter control; all forced low while in reset
  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ctr_clear = 1'b0;
    ctr_en    = 1'b0;
    if (rst_n_sync) begin
      unique case (state_q)
        MA_IDLE: begin
          ctr_clear = 1'b1;
          if (valid_in && mem_op) begin
            if (aligned) begin
              mem_req   = 1'b1;
              mem_we    = instr_in.is_st;
              mem_addr  = aluResult_in;
              mem_wdata = op2;
              stall     = ~mem_ack;
            end else begin
              stall = 1'b1;
            end
          end
        end
        MA_ACCESS: begin
          mem_req   = 1'b1;
          mem_we    = instr_q.is_st;
          mem_addr  = instr_q.alu;
          mem_wdata = instr_q.op2;
          stall     = ~mem_ack;
          ctr_en    = ~mem_ack;
        end
        MA_ERROR: stall = 1'b1;
        default:  stall = 1'b0;
      endcase
    end
  end

  // Downstream registers; valid_out and isWb are single-cycle pulses
  always_ff @(posedge Clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      wb_q    <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      wb_q    <= 1'b0;
      unique case (state_q)
        MA_IDLE: begin
          if (valid_in) begin
            instr_q <= instr_in;
            if (!mem_op) begin
              valid_q <= 1'b1;
              wb_q    <= isWb_in;
            end else if (!aligned) begin
              valid_q <= 1'b1;
              err_q   <= 1'b1;
            end else if (mem_ack) begin
              valid_q <= 1'b1;
              wb_q    <= isWb_in;
              if (isLd_in) ld_q <= mem_rdata;
            end
          end
        end
        MA_ACCESS: begin
          if (mem_ack) begin
            valid_q <= 1'b1;
            wb_q    <= instr_q.is_wb;
            if (instr_q.is_ld) ld_q <= mem_rdata;
          end else if (tmo_expired) begin
            valid_q <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_out  = valid_q;
  assign isWb       = wb_q;
  assign isCall     = instr_q.is_call;
  assign isLd       = instr_q.is_ld;
  assign Rd         = instr_q.rd;
  assign aluResult  = instr_q.alu;
  assign pc_current = instr_q.pc;
  assign ldResult   = ld_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage (timeout set to 4 cycles).
module tb_ma_stage;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        valid_in, isLd_in, isSt, isWb_in, isCall_in;
  logic [3:0]  Rd_in;
  logic [31:0] aluResult_in, op2, pc_in;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        valid_out, isWb, isCall, isLd;
  logic [3:0]  Rd;
  logic [31:0] aluResult, ldResult, pc_current;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  ma_stage #(.MEM_TIMEOUT(4)) dut (
    .Clk(Clk), .reset_n(reset_n),
    .valid_in(valid_in), .isLd_in(isLd_in), .isSt(isSt), .isWb_in(isWb_in),
    .isCall_in(isCall_in), .Rd_in(Rd_in), .aluResult_in(aluResult_in),
    .op2(op2), .pc_in(pc_in), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .valid_out(valid_out), .isWb(isWb), .isCall(isCall), .isLd(isLd),
    .Rd(Rd), .aluResult(aluResult), .ldResult(ldResult),
    .pc_current(pc_current), .mem_err(mem_err)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; isLd_in = 0; isSt = 0; isWb_in = 0; isCall_in = 0;
    Rd_in = 0; aluResult_in = 0; op2 = 0; pc_in = 0;
    mem_rdata = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    repeat (2) tick();
    @(negedge Clk);
    reset_n = 1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    valid_in = 1; isLd_in = 1; aluResult_in = 32'h40; mem_ack = 1;
    #1;
    total++;
    if ({mem_req, stall, valid_out, isWb, mem_err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: req/stall/vo/wb/err=%b want 00000",
                      {mem_req, stall, valid_out, isWb, mem_err});
    end
    total++;
    if ({mem_addr, ldResult, aluResult, pc_current} !== 128'h0) begin
      bad++; $display("FAIL reset_bus: addr=%h ld=%h alu=%h pc=%h want 0",
                      mem_addr, ldResult, aluResult, pc_current);
    end
    do_reset();
  endtask

  task automatic test_add();
    valid_in = 1; isWb_in = 1; Rd_in = 3; aluResult_in = 32'h10; pc_in = 32'h100;
    #1;
    total++;
    if ({mem_req, stall} !== 2'b00) begin
      bad++; $display("FAIL add_issue: req/stall=%b want 00", {mem_req, stall});
    end
    tick();
    clear_inputs();
    total++;
    if ({valid_out, isWb, isLd, isCall} !== 4'b1100 || aluResult !== 32'h10 ||
        Rd !== 4'd3 || pc_current !== 32'h100 || mem_req !== 1'b0) begin
      bad++; $display("FAIL add_out: vo=%b wb=%b ld=%b alu=%h rd=%0d pc=%h req=%b want 1 1 0 10 3 100 0",
                      valid_out, isWb, isLd, aluResult, Rd, pc_current, mem_req);
    end
    tick();
    total++;
    if ({valid_out, isWb} !== 2'b00) begin
      bad++; $display("FAIL add_pulse: vo/wb=%b want 00", {valid_out, isWb});
    end
  endtask

  task automatic test_load_wait();
    int stall_hi = 0;
    int early_vo = 0;
    int req_bad  = 0;
    valid_in = 1; isLd_in = 1; isWb_in = 1; Rd_in = 5;
    aluResult_in = 32'h40; pc_in = 32'h104;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
      #1;
      if (stall) stall_hi++;
      if (valid_out) early_vo++;
      if (!mem_req || mem_we || mem_addr !== 32'h40) req_bad++;
      tick();
    end
    clear_inputs();
    total++;
    if (stall_hi != 3) begin
      bad++; $display("FAIL ld_stall: stall high %0d cycles want 3", stall_hi);
    end
    total++;
    if (early_vo != 0 || req_bad != 0) begin
      bad++; $display("FAIL ld_access: early_vo=%0d req_bad=%0d want 0 0", early_vo, req_bad);
    end
    total++;
    if (valid_out !== 1'b1 || ldResult !== 32'hDEADBEEF || isWb !== 1'b1 ||
        isLd !== 1'b1 || Rd !== 4'd5) begin
      bad++; $display("FAIL ld_done: vo=%b ld=%h wb=%b isLd=%b rd=%0d want 1 deadbeef 1 1 5",
                      valid_out, ldResult, isWb, isLd, Rd);
    end
    tick();
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL ld_pulse: vo=%b want 0", valid_out);
    end
  endtask

  task automatic test_store_same_cycle();
    valid_in = 1; isSt = 1; aluResult_in = 32'h44; op2 = 32'h12345678;
    pc_in = 32'h108; mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    total++;
    if ({mem_req, mem_we, stall} !== 3'b110 || mem_addr !== 32'h44 ||
        mem_wdata !== 32'h12345678) begin
      bad++; $display("FAIL st_issue: req/we/stall=%b addr=%h wdata=%h want 110 44 12345678",
                      {mem_req, mem_we, stall}, mem_addr, mem_wdata);
    end
    tick();
    clear_inputs();
    total++;
    if (valid_out !== 1'b1 || ldResult !== 32'hDEADBEEF || isWb !== 1'b0) begin
      bad++; $display("FAIL st_done: vo=%b ld=%h wb=%b want 1 deadbeef 0",
                      valid_out, ldResult, isWb);
    end
  endtask

  task automatic test_ld_st_both();
    valid_in = 1; isLd_in = 1; isSt = 1; aluResult_in = 32'h48; op2 = 32'h55;
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    #1;
    total++;
    if ({mem_req, mem_we} !== 2'b10) begin
      bad++; $display("FAIL both_issue: req/we=%b want 10", {mem_req, mem_we});
    end
    tick();
    clear_inputs();
    total++;
    if (valid_out !== 1'b1 || ldResult !== 32'h0BADF00D) begin
      bad++; $display("FAIL both_done: vo=%b ld=%h want 1 0badf00d", valid_out, ldResult);
    end
  endtask

  task automatic test_misaligned();
    valid_in = 1; isLd_in = 1; isWb_in = 1; aluResult_in = 32'h42;
    #1;
    total++;
    if ({mem_req, stall} !== 2'b01) begin
      bad++; $display("FAIL mis_issue: req/stall=%b want 01", {mem_req, stall});
    end
    tick();
    total++;
    if ({valid_out, isWb, mem_err, stall, mem_req} !== 5'b10110) begin
      bad++; $display("FAIL mis_err: vo/wb/err/stall/req=%b want 10110",
                      {valid_out, isWb, mem_err, stall, mem_req});
    end
    // Stray ack and a new instruction while in error
    isLd_in = 0; aluResult_in = 32'h20; mem_ack = 1;
    tick();
    tick();
    total++;
    if ({valid_out, mem_err, stall, mem_req} !== 4'b0110) begin
      bad++; $display("FAIL mis_sticky: vo/err/stall/req=%b want 0110",
                      {valid_out, mem_err, stall, mem_req});
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    int vo_cnt  = 0;
    int vo_at   = -1;
    int last_req = -1;
    valid_in = 1; isLd_in = 1; isWb_in = 1; aluResult_in = 32'h80;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mem_req) begin req_cnt++; last_req = c; end
      if (valid_out) begin vo_cnt++; vo_at = c; end
      tick();
    end
    total++;
    // Issue cycle plus four unanswered wait cycles
    if (req_cnt != 5 || last_req != 4) begin
      bad++; $display("FAIL tmo_req: req cycles=%0d last=%0d want 5 4", req_cnt, last_req);
    end
    total++;
    if (vo_cnt != 1 || vo_at != 5) begin
      bad++; $display("FAIL tmo_vo: count=%0d at=%0d want 1 5", vo_cnt, vo_at);
    end
    total++;
    if ({mem_err, stall, isWb} !== 3'b110) begin
      bad++; $display("FAIL tmo_err: err/stall/wb=%b want 110", {mem_err, stall, isWb});
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_access();
    int vo_seen = 0;
    int req_seen = 0;
    valid_in = 1; isLd_in = 1; isWb_in = 1; Rd_in = 7;
    aluResult_in = 32'h40; pc_in = 32'h200;
    tick();
    tick();
    #1;
    total++;
    if ({mem_req, stall} !== 2'b11) begin
      bad++; $display("FAIL rst_pre: req/stall=%b want 11", {mem_req, stall});
    end
    reset_n = 0;
    #1;
    total++;
    if ({mem_req, stall, valid_out, isWb, mem_err, isLd} !== 6'b0 ||
        {mem_addr, aluResult, pc_current, ldResult} !== 128'h0 || Rd !== 4'd0) begin
      bad++; $display("FAIL rst_mid: ctrl=%b addr=%h alu=%h pc=%h ld=%h rd=%0d want all 0",
                      {mem_req, stall, valid_out, isWb, mem_err, isLd},
                      mem_addr, aluResult, pc_current, ldResult, Rd);
    end
    clear_inputs();
    repeat (2) tick();
    @(negedge Clk);
    reset_n = 1;
    mem_ack = 1; mem_rdata = 32'h11112222;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (valid_out) vo_seen++;
      if (mem_req || stall) req_seen++;
    end
    total++;
    if (vo_seen != 0 || req_seen != 0 || ldResult !== 32'h0) begin
      bad++; $display("FAIL rst_stray_ack: vo=%0d req/stall=%0d ld=%h want 0 0 0",
                      vo_seen, req_seen, ldResult);
    end
    mem_ack = 0;
    valid_in = 1; isWb_in = 1; Rd_in = 2; aluResult_in = 32'h33;
    tick();
    clear_inputs();
    total++;
    if (valid_out !== 1'b1 || aluResult !== 32'h33 || Rd !== 4'd2) begin
      bad++; $display("FAIL rst_idle: vo=%b alu=%h rd=%0d want 1 33 2", valid_out, aluResult, Rd);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store_same_cycle();
    test_ld_st_both();
    test_misaligned();
    do_reset();
    test_timeout();
    do_reset();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
